timer_bcd_mmss: RTL and testbench
=================================

Name: timer_bcd_mmss

Overview:
- Parametrised successor to the microwave countdown timer.
- Digits are keyed in serially from the keypad encoder into a BCD MM:SS register. The block then counts down once per TICK_DIV clocks under an explicit start/stop handshake, with pause and clear.
- Minute field width is set by MIN_DIGITS.
- Feeds the display driver and the magnetron/door controller: `zero`, `tc` and `running` are the control-side outputs.

Parameters:
- MIN_DIGITS, 1, number of BCD minute digits (1..3).
- TICK_DIV, 1, clock cycles per one-second decrement (1 = every enabled clock, for simulation).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clrn  in  1  reset, synchronous, active-low.
- data  in  4  keypad digit, BCD.
- loadn  in  1  active-low digit strobe; one digit shifted in per clock while low.
- en  in  1  count enable (door closed); gates the prescaler only.
- start  in  1  start/resume request, sampled per clock.
- stop  in  1  pause request; while PAUSED, clears to IDLE.
- sec_ones  out  4  seconds units, BCD.
- sec_tens  out  4  seconds tens, BCD (0..9 on entry).
- mins  out  4*MIN_DIGITS  minutes, BCD; least-significant digit in [3:0].
- zero  out  1  high when all digits are 0.
- tc  out  1  one-cycle pulse on a countdown reaching 0.
- running  out  1  high in RUNNING.

Behaviour:
- Reset (clrn=0 at an edge):
  - All digits 0, prescaler 0, state IDLE.
  - zero=1, tc=0, running=0.
  - Reset overrides all other inputs, including mid-run.
- States: IDLE, RUNNING, PAUSED, DONE.
- Digit entry:
  - Accepted only in IDLE, PAUSED or DONE, and only when loadn=0 and data<=9.
  - Entry shifts left one digit: mins <= {mins[4*MIN_DIGITS-5:0], sec_tens}; sec_tens <= sec_ones; sec_ones <= data. The top minute digit is discarded.
  - data 10..15 is ignored.
  - In DONE, an accepted digit moves the state to IDLE.
  - In RUNNING, loadn is ignored.
- Transitions:
  - IDLE/PAUSED -> RUNNING on start=1 when zero=0. start with zero=1 is ignored.
  - RUNNING -> PAUSED on stop=1. stop has priority over start in the same cycle.
  - PAUSED -> IDLE on stop=1. Digits and prescaler are cleared.
  - RUNNING -> DONE when a decrement produces all-zero. tc=1 for exactly that cycle.
  - DONE -> RUNNING never directly; new digits must be entered first.
- Prescaler:
  - Counts 0..TICK_DIV-1 only when state=RUNNING and en=1. Holds when en=0.
  - A decrement occurs on the cycle the prescaler wraps.
  - The prescaler is cleared on entry to RUNNING from IDLE, and retained across PAUSED.
- Decrement, BCD borrow chain:
  - sec_ones 0 -> 9 with borrow; else -1.
  - On borrow: sec_tens 0 -> 5 with borrow to mins; else -1.
  - Minute digits: 0 -> 9 with borrow to the next digit; else -1.
  - sec_tens entered as 6..9 counts down naturally (e.g. 1:90 runs 150 s).
- Flag timing:
  - zero is registered alongside the digits, i.e. it reflects the current register contents.
  - running is high exactly in RUNNING.
- Simultaneous events: loadn=0 together with start in IDLE — the digit is shifted first, and start is evaluated against the pre-shift zero.

Optional Feature:
- Macro: TIMER_ADD30_EN.
- Defined:
  - start=1 while RUNNING (stop=0) adds 30 s in one cycle.
  - sec_tens += 3. If the result is >=6, subtract 6 and increment mins, with a BCD carry chain.
  - If mins is all 9s and a carry out would occur, saturate all digits to mins=all 9s, sec_tens=5, sec_ones=9.
  - A decrement tick in the same cycle is applied first, then the add.
- Not defined: start while RUNNING is ignored.

Test Plan:
- Load "4","5","7" with MIN_DIGITS=1, TICK_DIV=1 -> mins=4, sec_tens=5, sec_ones=7, zero=0, state IDLE; then start -> 4:56 one clock after RUNNING, and tc pulses exactly once after 297 decrements with zero=1, running=0.
- Load 1:00, start, en=1 -> after 1 tick 0:59; after 60 ticks 0:00, DONE, tc=1 for one cycle.
- TICK_DIV=4, load 0:03, start, toggle en low for 5 cycles mid-count -> decrements every 4 enabled cycles only, with no decrement while en=0.
- Running at 0:40: stop -> PAUSED, value held; start -> resumes; stop, stop -> IDLE with all digits 0, zero=1.
- MIN_DIGITS=2, load 9,9,5,9 -> mins=0x99, sec=59; load 1 more digit -> mins=0x95, sec_tens=9, sec_ones=1; data=12 with loadn=0 -> no change; clrn=0 mid-run -> all 0 next edge.
- With TIMER_ADD30_EN, running at 1:45, start -> 2:15; at 9:59 (MIN_DIGITS=1) start -> saturates to 9:59.

Source files
------------

// File: rtl/timer_bcd_mmss.sv
// ---------------------------------------------------------------------------
// timer_bcd_mmss
//   BCD MM:SS countdown timer. Digits are keyed in serially (shift-left),
//   then counted down once per TICK_DIV enabled clocks under a start/stop
//   handshake with pause and clear.
//
// Parameters:
//   MIN_DIGITS : number of BCD minute digits (1..3)
//   TICK_DIV   : clocks per one-second decrement (1 = every enabled clock)
//
// Optional feature (macro TIMER_ADD30_EN):
//   defined     -> start while RUNNING (stop=0) adds 30 s, saturating at
//                  all-9s minutes, 59 seconds.
//   not defined -> start while RUNNING is ignored.
//
// Ports:
//   clk       in   clock, rising edge
//   clrn      in   synchronous active-low reset
//   data      in   keypad digit (BCD, 10..15 ignored)
//   loadn     in   active-low digit strobe
//   en        in   count enable (gates the prescaler only)
//   start     in   start/resume request
//   stop      in   pause request; clears to IDLE when already paused
//   sec_ones  out  seconds units
//   sec_tens  out  seconds tens
//   mins      out  minutes, least-significant digit in [3:0]
//   zero      out  all digits zero
//   tc        out  one-cycle pulse when a countdown reaches zero
//   running   out  high in RUNNING
// ---------------------------------------------------------------------------
module timer_bcd_mmss #(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic [3:0]                data,
    input  logic                      loadn,
    input  logic                      en,
    input  logic                      start,
    input  logic                      stop,
    output logic [3:0]                sec_ones,
    output logic [3:0]                sec_tens,
    output logic [4*MIN_DIGITS-1:0]   mins,
    output logic                      zero,
    output logic                      tc,
    output logic                      running
);

    localparam int ND = MIN_DIGITS + 2;   // total digit count
    localparam int DW = 4 * ND;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    // All digits packed as {mins, sec_tens, sec_ones}.
    logic [DW-1:0] digits_q, digits_d;
    logic [PW-1:0] presc_q, presc_d;
    state_e        state_q, state_d;
    logic          zero_q, zero_d;
    logic          tc_q, tc_d;
    logic          running_q, running_d;

    logic          load_ok;
    logic [DW-1:0] shifted;
    logic [DW-1:0] next_val;
    logic          ticked;

    // BCD decrement; sec_tens borrows from 0 to 5, every other digit to 9.
    function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          borrow;
        logic [3:0]    d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < ND; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                    borrow      = 1'b1;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

`ifdef TIMER_ADD30_EN
    // Add 30 s: sec_tens += 3 with carry into minutes; saturate on overflow.
    function automatic logic [DW-1:0] bcd_add30(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic          carry;
        logic [4:0]    t;
        logic [3:0]    d;
        r = v;
        t = {1'b0, v[7:4]} + 5'd3;
        if (t >= 5'd6) begin
            r[7:4] = 4'(t - 5'd6);
            carry  = 1'b1;
        end else begin
            r[7:4] = t[3:0];
            carry  = 1'b0;
        end
        for (int i = 2; i < ND; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        if (carry) begin
            r = {{MIN_DIGITS{4'd9}}, 4'd5, 4'd9};
        end else begin
            r = r;
        end
        return r;
    endfunction
`endif

    assign load_ok = !loadn && (data <= 4'd9);
    assign shifted = {digits_q[DW-5:0], data};

    // Next-state, digit, prescaler and flag computation.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        tc_d     = 1'b0;
        next_val = digits_q;
        ticked   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_ok) begin
                    digits_d = shifted;
                end else begin
                    digits_d = digits_q;
                end
                // start is qualified by the pre-shift zero flag
                if (start && !zero_q) begin
                    state_d = S_RUNNING;
                    presc_d = {PW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PAUSED: begin
                if (stop) begin
                    state_d  = S_IDLE;
                    digits_d = {DW{1'b0}};
                    presc_d  = {PW{1'b0}};
                end else begin
                    if (load_ok) begin
                        digits_d = shifted;
                    end else begin
                        digits_d = digits_q;
                    end
                    // prescaler phase is kept across the pause
                    if (start && !zero_q) begin
                        state_d = S_RUNNING;
                    end else begin
                        state_d = S_PAUSED;
                    end
                end
            end
            S_RUNNING: begin
                if (stop) begin
                    // pause freezes both digits and prescaler this cycle
                    state_d = S_PAUSED;
                end else begin
                    if (en) begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d  = {PW{1'b0}};
                            next_val = bcd_dec(digits_q);
                            ticked   = 1'b1;
                        end else begin
                            presc_d  = presc_q + PW'(1);
                        end
                    end else begin
                        presc_d = presc_q;
                    end
`ifdef TIMER_ADD30_EN
                    // add applies on top of any decrement in the same cycle
                    if (start) begin
                        next_val = bcd_add30(next_val);
                    end else begin
                        next_val = next_val;
                    end
`endif
                    digits_d = next_val;
                    if (ticked && (next_val == {DW{1'b0}})) begin
                        state_d = S_DONE;
                        tc_d    = 1'b1;
                    end else begin
                        state_d = S_RUNNING;
                    end
                end
            end
            S_DONE: begin
                if (load_ok) begin
                    digits_d = shifted;
                    state_d  = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        zero_d    = (digits_d == {DW{1'b0}});
        running_d = (state_d == S_RUNNING);
    end

    // State, digit, prescaler and output-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            digits_q  <= {DW{1'b0}};
            presc_q   <= {PW{1'b0}};
            zero_q    <= 1'b1;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            presc_q   <= presc_d;
            zero_q    <= zero_d;
            tc_q      <= tc_d;
            running_q <= running_d;
        end
    end

    assign sec_ones = digits_q[3:0];
    assign sec_tens = digits_q[7:4];
    assign mins     = digits_q[DW-1:8];
    assign zero     = zero_q;
    assign tc       = tc_q;
    assign running  = running_q;

endmodule

// File: tb/tb_timer_bcd_mmss.sv
// ---------------------------------------------------------------------------
// tb_timer_bcd_mmss
//   Directed bench. Three instances share one stimulus bus:
//   u1 (MIN_DIGITS=1, TICK_DIV=1), u2 (MIN_DIGITS=2, TICK_DIV=1),
//   u4 (MIN_DIGITS=1, TICK_DIV=4). Each scenario resets first and only
//   examines the instance it targets.
// ---------------------------------------------------------------------------
module tb_timer_bcd_mmss;

    logic       clk = 1'b0;
    logic       clrn, loadn, en, start, stop;
    logic [3:0] data;

    logic [3:0] o1, t1, m1;
    logic       z1, tc1, r1;
    logic [3:0] o2, t2;
    logic [7:0] m2;
    logic       z2, tc2, r2;
    logic [3:0] o4, t4, m4;
    logic       z4, tc4, r4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_bcd_mmss #(.MIN_DIGITS(1), .TICK_DIV(1)) u1 (
        .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en),
        .start(start), .stop(stop), .sec_ones(o1), .sec_tens(t1), .mins(m1),
        .zero(z1), .tc(tc1), .running(r1));

    timer_bcd_mmss #(.MIN_DIGITS(2), .TICK_DIV(1)) u2 (
        .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en),
        .start(start), .stop(stop), .sec_ones(o2), .sec_tens(t2), .mins(m2),
        .zero(z2), .tc(tc2), .running(r2));

    timer_bcd_mmss #(.MIN_DIGITS(1), .TICK_DIV(4)) u4 (
        .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .en(en),
        .start(start), .stop(stop), .sec_ones(o4), .sec_tens(t4), .mins(m4),
        .zero(z4), .tc(tc4), .running(r4));

    // advance one rising edge and settle
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        data  = d;
        loadn = 1'b0;
        cyc();
        loadn = 1'b1;
        data  = 4'd0;
    endtask

    task automatic do_reset();
        clrn = 1'b0; start = 1'b0; stop = 1'b0; loadn = 1'b1; en = 1'b1; data = 4'd0;
        cyc();
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; start = 1'b1; loadn = 1'b0; data = 4'd5; stop = 1'b0; en = 1'b1;
        cyc();
        clrn = 1'b1; start = 1'b0; loadn = 1'b1;
        checks++; if ({m1, t1, o1} !== 12'h000) begin failures++; $display("FAIL rst_digits got=%h exp=000", {m1, t1, o1}); end
        checks++; if ({z1, tc1, r1} !== 3'b100) begin failures++; $display("FAIL rst_flags got=%b exp=100", {z1, tc1, r1}); end
        checks++; if ({m4, t4, o4, z4, tc4, r4} !== 15'b000000000000100) begin failures++; $display("FAIL rst_u4 got=%b", {m4, t4, o4, z4, tc4, r4}); end
    endtask

    task automatic test_load_run();
        int tc_cnt;
        int tc_at;
        do_reset();
        key(4'd4); key(4'd5); key(4'd7);
        checks++; if ({m1, t1, o1} !== 12'h457) begin failures++; $display("FAIL ld457 got=%h exp=457", {m1, t1, o1}); end
        checks++; if ({z1, r1} !== 2'b00) begin failures++; $display("FAIL ld457_flags got=%b exp=00", {z1, r1}); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL run457_running got=%b exp=1", r1); end
        cyc();
        checks++; if ({m1, t1, o1} !== 12'h456) begin failures++; $display("FAIL run456 got=%h exp=456", {m1, t1, o1}); end
        tc_cnt = 0; tc_at = 0;
        for (int k = 2; k <= 300; k++) begin
            cyc();
            if (tc1 === 1'b1) begin tc_cnt++; tc_at = k; end
        end
        checks++; if (tc_cnt !== 1) begin failures++; $display("FAIL tc_count got=%0d exp=1", tc_cnt); end
        checks++; if (tc_at !== 297) begin failures++; $display("FAIL tc_when got=%0d exp=297", tc_at); end
        checks++; if ({z1, r1} !== 2'b10) begin failures++; $display("FAIL done_flags got=%b exp=10", {z1, r1}); end
    endtask

    task automatic test_one_minute();
        do_reset();
        key(4'd1); key(4'd0); key(4'd0);
        checks++; if ({m1, t1, o1} !== 12'h100) begin failures++; $display("FAIL ld100 got=%h exp=100", {m1, t1, o1}); end
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        checks++; if ({m1, t1, o1} !== 12'h059) begin failures++; $display("FAIL borrow059 got=%h exp=059", {m1, t1, o1}); end
        for (int k = 2; k <= 60; k++) cyc();
        checks++; if ({tc1, z1, r1} !== 3'b110) begin failures++; $display("FAIL min_done got=%b exp=110", {tc1, z1, r1}); end
        cyc();
        checks++; if (tc1 !== 1'b0) begin failures++; $display("FAIL tc_single got=%b exp=0", tc1); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (r1 !== 1'b0) begin failures++; $display("FAIL done_start got=%b exp=0", r1); end
        key(4'd5);
        checks++; if ({m1, t1, o1, z1} !== 13'h00a) begin failures++; $display("FAIL done_key got=%h exp=00a", {m1, t1, o1, z1}); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL restart got=%b exp=1", r1); end
    endtask

    task automatic test_prescaler();
        do_reset();
        key(4'd3);
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if ({r4, o4} !== 5'h13) begin failures++; $display("FAIL ps_start got=%h exp=13", {r4, o4}); end
        repeat (3) cyc();
        checks++; if (o4 !== 4'd3) begin failures++; $display("FAIL ps_3clk got=%0d exp=3", o4); end
        cyc();
        checks++; if (o4 !== 4'd2) begin failures++; $display("FAIL ps_4clk got=%0d exp=2", o4); end
        repeat (2) cyc();
        en = 1'b0;
        repeat (5) cyc();
        checks++; if ({r4, o4} !== 5'h12) begin failures++; $display("FAIL ps_en_low got=%h exp=12", {r4, o4}); end
        en = 1'b1;
        cyc();
        checks++; if (o4 !== 4'd2) begin failures++; $display("FAIL ps_resume1 got=%0d exp=2", o4); end
        cyc();
        checks++; if (o4 !== 4'd1) begin failures++; $display("FAIL ps_resume2 got=%0d exp=1", o4); end
    endtask

    task automatic test_pause();
        do_reset();
        key(4'd4); key(4'd0);
        start = 1'b1; cyc(); start = 1'b0;
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if ({r1, m1, t1, o1} !== 13'h0040) begin failures++; $display("FAIL pause got=%h exp=0040", {r1, m1, t1, o1}); end
        repeat (3) cyc();
        checks++; if ({m1, t1, o1} !== 12'h040) begin failures++; $display("FAIL pause_hold got=%h exp=040", {m1, t1, o1}); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL resume got=%b exp=1", r1); end
        cyc();
        checks++; if ({m1, t1, o1} !== 12'h039) begin failures++; $display("FAIL resume_dec got=%h exp=039", {m1, t1, o1}); end
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        checks++; if ({r1, m1, t1, o1} !== 13'h0039) begin failures++; $display("FAIL stop_prio got=%h exp=0039", {r1, m1, t1, o1}); end
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if ({m1, t1, o1, z1, r1} !== 14'b00000000000010) begin failures++; $display("FAIL clear got=%b", {m1, t1, o1, z1, r1}); end
    endtask

    task automatic test_entry();
        do_reset();
        key(4'd9); key(4'd9); key(4'd5); key(4'd9);
        checks++; if ({m2, t2, o2} !== 16'h9959) begin failures++; $display("FAIL ent9959 got=%h exp=9959", {m2, t2, o2}); end
        key(4'd1);
        checks++; if ({m2, t2, o2} !== 16'h9591) begin failures++; $display("FAIL ent_drop got=%h exp=9591", {m2, t2, o2}); end
        key(4'd12);
        checks++; if ({m2, t2, o2} !== 16'h9591) begin failures++; $display("FAIL ent_bad got=%h exp=9591", {m2, t2, o2}); end
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        checks++; if ({m2, t2, o2} !== 16'h9590) begin failures++; $display("FAIL ent_dec got=%h exp=9590", {m2, t2, o2}); end
        clrn = 1'b0; start = 1'b1; loadn = 1'b0; data = 4'd7;
        cyc();
        clrn = 1'b1; start = 1'b0; loadn = 1'b1;
        checks++; if ({m2, t2, o2} !== 16'h0000) begin failures++; $display("FAIL midrun_rst got=%h exp=0000", {m2, t2, o2}); end
        checks++; if ({z2, tc2, r2} !== 3'b100) begin failures++; $display("FAIL midrun_flags got=%b exp=100", {z2, tc2, r2}); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        data = 4'd5; loadn = 1'b0; start = 1'b1;
        cyc();
        checks++; if ({r1, o1} !== 5'h05) begin failures++; $display("FAIL sim_zero got=%h exp=05", {r1, o1}); end
        data = 4'd3;
        cyc();
        loadn = 1'b1; start = 1'b0;
        checks++; if ({r1, m1, t1, o1} !== 13'h1053) begin failures++; $display("FAIL sim_start got=%h exp=1053", {r1, m1, t1, o1}); end
        data = 4'd7; loadn = 1'b0;
        cyc();
        loadn = 1'b1;
        checks++; if ({m1, t1, o1} !== 12'h052) begin failures++; $display("FAIL run_noload got=%h exp=052", {m1, t1, o1}); end
    endtask

    task automatic test_add30();
        do_reset();
        key(4'd1); key(4'd4); key(4'd5);
        start = 1'b1; cyc(); cyc(); start = 1'b0;
`ifdef TIMER_ADD30_EN
        checks++; if ({r4, m4, t4, o4} !== 13'h1215) begin failures++; $display("FAIL add30 got=%h exp=1215", {r4, m4, t4, o4}); end
`else
        checks++; if ({r4, m4, t4, o4} !== 13'h1145) begin failures++; $display("FAIL start_ign got=%h exp=1145", {r4, m4, t4, o4}); end
`endif
        do_reset();
        key(4'd9); key(4'd5); key(4'd9);
        start = 1'b1; cyc(); cyc(); start = 1'b0;
        checks++; if ({r4, m4, t4, o4} !== 13'h1959) begin failures++; $display("FAIL add30_sat got=%h exp=1959", {r4, m4, t4, o4}); end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_one_minute();
        test_prescaler();
        test_pause();
        test_entry();
        test_simultaneous();
        test_add30();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
